// File: rtl/muldiv_if.sv
// Operand/result bundle between the issue stage and the iterative
// multiply/divide unit: request side (start, funct3, operands, flush)
// and response side (busy, done, result).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // Issue stage drives requests and watches the handshake.
    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    // Execution unit consumes requests and reports completion.
    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring-divide step per cycle, WIDTH steps.
// Signed operations run on magnitudes; the sign is fixed up as the last
// step lands, so the result is ready in the single DONE cycle.
// hi_reg/lo_reg are shared: {product_hi, product_lo} for multiply and
// {remainder, quotient} for divide.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         funct3_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   mcand_reg;     // multiplicand magnitude, or divisor magnitude
    logic               neg_reg;       // product / quotient must be negated
    logic               neg_rem_reg;   // remainder must be negated
    logic [WIDTH-1:0]   result_reg;

    // Operand conditioning for the request currently on the bus.
    logic               a_signed;
    logic               b_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               is_div;
    logic               div_by_zero;

    // One iteration step and the sign-fixed final value.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   iter_hi;
    logic [WIDTH-1:0]   iter_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   final_res;
    logic               unused_diff_bit;

    // Decode signedness of the incoming op and form operand magnitudes.
    always_comb begin
        a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
        a_mag       = (a_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        b_mag       = (b_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        is_div      = bus.funct3[2];
        div_by_zero = is_div && (bus.op_b == '0);
    end

    // One multiply or divide step, plus the sign-corrected result it implies.
    always_comb begin
        // Shift-add: add multiplicand when multiplier LSB is set, then shift right.
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
        // Restoring divide: shift next dividend bit in, subtract if it fits.
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_reg};
        div_ok    = ~div_diff[WIDTH+1];
        unused_diff_bit = div_diff[WIDTH];
        if (funct3_reg[2]) begin
            iter_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            iter_lo = {lo_reg[WIDTH-2:0], div_ok};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
        prod_fix = neg_reg ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
        quo_fix  = neg_reg ? -iter_lo : iter_lo;
        rem_fix  = neg_rem_reg ? -iter_hi : iter_hi;
        if (funct3_reg[2]) begin
            final_res = funct3_reg[1] ? rem_fix : quo_fix;
        end else begin
            final_res = (funct3_reg[1:0] == 2'b00) ? prod_fix[WIDTH-1:0]
                                                   : prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            funct3_reg  <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            mcand_reg   <= '0;
            neg_reg     <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        funct3_reg  <= bus.funct3;
                        cnt_reg     <= '0;
                        hi_reg      <= '0;
                        neg_reg     <= (a_signed && bus.op_a[WIDTH-1]) ^
                                       (b_signed && bus.op_b[WIDTH-1]);
                        neg_rem_reg <= a_signed && bus.op_a[WIDTH-1];
                        lo_reg      <= is_div ? a_mag : b_mag;
                        mcand_reg   <= is_div ? b_mag : a_mag;
                        if (div_by_zero) begin
                            // Quotient of x/0 is all ones, remainder is x.
                            result_reg <= bus.funct3[1] ? bus.op_a : '1;
                            state_reg  <= S_DONE;
                        end else begin
                            state_reg  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        state_reg <= S_IDLE;
                    end else begin
                        hi_reg  <= iter_hi;
                        lo_reg  <= iter_lo;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                            result_reg <= final_res;
                            state_reg  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_reg != S_IDLE);
    assign bus.done   = (state_reg == S_DONE);
    assign bus.result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit: expected results are queued
// when a request is issued and compared when done pulses.
module tb_muldiv_unit;
    logic clk;
    logic reset;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent arithmetic reference using 64-bit integer math.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issue one op; mode 1 pulses a second start while busy.
    // Operands and funct3 are scrambled right after acceptance in every run.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int mode);
        int          lat, busy_cnt, exp_lat, extra;
        bit          seen;
        logic [31:0] want;
        exp_lat = (f[2] && b == 32'h0) ? 1 : 33;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        sb_q.push_back(exp);
        @(posedge clk);
        lat = 0; busy_cnt = 0; seen = 1'b0; want = '0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen = 1'b1;
                want = sb_q.pop_front();
                check($sformatf("%s result", tag), bus.result, want);
            end
            if (lat == 1) begin
                bus.start  = 1'b0;
                bus.op_a   = ~a;
                bus.op_b   = $urandom;
                bus.funct3 = 3'($urandom);
            end
            if (mode == 1 && lat == 5) bus.start = 1'b1;
            if (mode == 1 && lat == 6) bus.start = 1'b0;
        end
        check($sformatf("%s latency", tag), lat, exp_lat);
        check($sformatf("%s busy_cycles", tag), busy_cnt, exp_lat);
        @(negedge clk);
        check($sformatf("%s idle_after", tag), {30'b0, bus.busy, bus.done}, 32'h0);
        if (mode == 1) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            check($sformatf("%s extra_done", tag), extra, 0);
        end
        $display("[TB] %s f=%0d a=%h b=%h -> result=%h latency=%0d", tag, f, a, b, want, lat);
        last_result = exp;
    endtask

    initial begin
        int          dones;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.flush  = 1'b0;
        last_result = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, bus.busy}, 32'h0);
        check("reset done", {31'b0, bus.done}, 32'h0);
        check("reset result", bus.result, 32'h0);
        reset = 1'b0;

        // Directed arithmetic cases.
        run_op("MUL",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("MULH",       3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op("MULHU",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("MULHSU",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("DIV",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op("REM",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("DIVU",       3'd5, 32'd100,        32'd7,         32'd14,        0);
        run_op("REMU",       3'd7, 32'd100,        32'd7,         32'd2,         0);
        run_op("DIVU_by0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("REM_by0",    3'd6, 32'd5,          32'd0,         32'd5,         0);
        run_op("DIV_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("REM_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         0);
        run_op("MUL_2start", 3'd0, 32'd1234,       32'd5678,      32'd7006652,   1);

        // Random ops against the reference model, including a divide by zero.
        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : $urandom;
            if (i == 3) rf = 3'd4;
            run_op($sformatf("RAND%0d", i), rf, ra, rb, ref_model(rf, ra, rb), 0);
        end

        // Flush at iteration 10: back to IDLE, no done, result kept.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {31'b0, bus.busy}, 32'h0);
        check("flush done", {31'b0, bus.done}, 32'h0);
        check("flush result", bus.result, last_result);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("flush no_done", dones, 0);
        $display("[TB] FLUSH at iteration 10 -> result=%h", bus.result);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd1; bus.op_a = 32'h1234_5678; bus.op_b = 32'h9ABC_DEF0;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset busy", {31'b0, bus.busy}, 32'h0);
        check("midreset done", {31'b0, bus.done}, 32'h0);
        check("midreset result", bus.result, 32'h0);
        reset = 1'b0;
        $display("[TB] RESET mid-op -> result=%h", bus.result);

        // Unit recovers cleanly after the reset.
        run_op("post_reset", 3'd7, 32'd1000, 32'd33, 32'd10, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
